ebu_arbiter_fsm: RTL and testbench



---
 rtl/ebu_pkg.sv | 35 +++
 rtl/ebu_beatcounter.sv | 29 ++
 rtl/ebu_arbiter_fsm.sv | 123 ++++++++++++
 tb/tb_ebu_arbiter_fsm.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ebu_pkg.sv
// Shared external-bus-unit definitions: AHB transfer/burst encodings, arbiter
// state codes and the HBURST-to-beat-count mapping.
package ebu_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } ahbtranstype;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef logic [1:0] arbstatetype;
  localparam arbstatetype IDLE = 2'd0;
  localparam arbstatetype ADDR = 2'd1;
  localparam arbstatetype DATA = 2'd2;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  // Undefined-length and wrapping encodings are arbitrated as single beats.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_INCR4:  burst_beats = 5'd4;
      HBURST_INCR8:  burst_beats = 5'd8;
      HBURST_INCR16: burst_beats = 5'd16;
      default:       burst_beats = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ebu_beatcounter.sv
// Remaining-beat counter for the owned burst: loaded at address accept,
// decremented on each accepted data beat.
module ebu_beatcounter #(
  parameter int BEATW = 5
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             load,
  input  logic [BEATW-1:0] load_val,
  input  logic             dec,
  output logic [BEATW-1:0] count,
  output logic             last
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == BEATW'(1));

endmodule

// File: rtl/ebu_arbiter_fsm.sv
// Two-requester AHB arbiter (LSU priority, bounded IFU starvation) holding
// ownership for the whole single/incrementing burst.
module ebu_arbiter_fsm
  import ebu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int BEATW        = 5
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HREADY,
  input  logic       LSUReq,
  input  logic       IFUReq,
  input  logic [2:0] LSUBurst,
  input  logic [2:0] IFUBurst,
  output logic       LSUGrant,
  output logic       IFUGrant,
  output logic       LSUDisable,
  output logic       IFUDisable,
  output logic       BusBusy
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arbstatetype      state, state_nxt;
  logic             owner, owner_nxt;
  logic [SW-1:0]    starve_cnt;
  logic [BEATW-1:0] beat_cnt;
  logic             beat_last;
  logic             ifu_turn, lsu_win, ifu_win;
  logic             cnt_load, cnt_dec;
  logic [2:0]       burst_sel;
  logic             lsu_sel, ifu_sel;

  assign ifu_turn = IFUReq && (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX);
  assign lsu_win  = LSUReq && !ifu_turn;
  assign ifu_win  = IFUReq && !lsu_win;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_load  = 1'b0;
    burst_sel = (owner == OWNER_LSU) ? LSUBurst : IFUBurst;
    case (state)
      IDLE: begin
        if (lsu_win || ifu_win) begin
          owner_nxt = lsu_win ? OWNER_LSU : OWNER_IFU;
          burst_sel = lsu_win ? LSUBurst : IFUBurst;
          if (HREADY) begin
            state_nxt = DATA;
            cnt_load  = 1'b1;
          end else begin
            state_nxt = ADDR;
          end
        end
      end
      ADDR: begin
        if (HREADY) begin
          state_nxt = DATA;
          cnt_load  = 1'b1;
        end
      end
      DATA: begin
        if (HREADY && beat_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_dec = (state == DATA) && HREADY;

  ebu_beatcounter #(.BEATW(BEATW)) u_beat (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .load     (cnt_load),
    .load_val (BEATW'(burst_beats(burst_sel))),
    .dec      (cnt_dec),
    .count    (beat_cnt),
    .last     (beat_last)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= IDLE;
      owner      <= OWNER_LSU;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if ((state == IDLE) && lsu_win && IFUReq && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end else if ((state == IDLE) && ifu_win) begin
        starve_cnt <= '0;
      end
    end
  end

  // In IDLE the winner is granted with zero latency; afterwards the owner holds.
  always_comb begin
    lsu_sel = 1'b0;
    ifu_sel = 1'b0;
    if (state == IDLE) begin
      lsu_sel = lsu_win;
      ifu_sel = ifu_win;
    end else begin
      lsu_sel = (owner == OWNER_LSU);
      ifu_sel = (owner == OWNER_IFU);
    end
  end

  // Gating with HRESET drops every output the instant reset asserts.
  assign LSUGrant   = lsu_sel & ~HRESET;
  assign IFUGrant   = ifu_sel & ~HRESET;
  assign LSUDisable = LSUReq & ~lsu_sel & ~HRESET;
  assign IFUDisable = IFUReq & ~ifu_sel & ~HRESET;
  assign BusBusy    = (state != IDLE) & ~HRESET;

endmodule

// File: tb/tb_ebu_arbiter_fsm.sv
// Directed scoreboard bench for ebu_arbiter_fsm: the driver queues the expected
// grant/disable/busy vector per cycle, a monitor compares at the falling edge.
module tb_ebu_arbiter_fsm;

  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR   = 3'b001;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;
  localparam logic [2:0] B_INCR16 = 3'b111;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       HREADY = 1'b0;
  logic       LSUReq = 1'b0;
  logic       IFUReq = 1'b0;
  logic [2:0] LSUBurst = 3'b000;
  logic [2:0] IFUBurst = 3'b000;
  logic       LSUGrant, IFUGrant, LSUDisable, IFUDisable, BusBusy;

  typedef struct {
    logic [4:0] bits;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 HCLK = ~HCLK;

  ebu_arbiter_fsm #(.STARVE_LIMIT(4), .BEATW(5)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HREADY     (HREADY),
    .LSUReq     (LSUReq),
    .IFUReq     (IFUReq),
    .LSUBurst   (LSUBurst),
    .IFUBurst   (IFUBurst),
    .LSUGrant   (LSUGrant),
    .IFUGrant   (IFUGrant),
    .LSUDisable (LSUDisable),
    .IFUDisable (IFUDisable),
    .BusBusy    (BusBusy)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; expected bits are {LSUGrant, IFUGrant, LSUDisable, IFUDisable, BusBusy}.
  task automatic step(input logic rst, input logic lr, input logic ir,
                      input logic [2:0] lb, input logic [2:0] ib, input logic hr,
                      input logic elg, input logic eig, input logic eb, input string nm);
    exp_t e;
    @(posedge HCLK);
    #1;
    HRESET   = rst;
    LSUReq   = lr;
    IFUReq   = ir;
    LSUBurst = lb;
    IFUBurst = ib;
    HREADY   = hr;
    e.bits = {elg, eig, lr & ~elg & ~rst, ir & ~eig & ~rst, eb};
    e.name = nm;
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      check("grant_mutex", {7'd0, LSUGrant & IFUGrant}, 8'd0);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, {3'd0, LSUGrant, IFUGrant, LSUDisable, IFUDisable, BusBusy}, {3'd0, e.bits});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic w_ifu;
    // Reset held with both requests high: every output must stay 0.
    step(1, 1, 1, B_SINGLE, B_SINGLE, 1, 0, 0, 0, "in_reset");
    step(1, 1, 1, B_SINGLE, B_SINGLE, 1, 0, 0, 0, "in_reset");
    step(0, 0, 0, B_SINGLE, B_SINGLE, 1, 0, 0, 0, "idle_after_reset");

    // LSU single: grant in cycle 0, DATA in cycle 1, IDLE in cycle 2.
    step(0, 1, 0, B_SINGLE, B_SINGLE, 1, 1, 0, 0, "lsu_single_addr");
    step(0, 1, 0, B_SINGLE, B_SINGLE, 1, 1, 0, 1, "lsu_single_data");
    step(0, 0, 0, B_SINGLE, B_SINGLE, 1, 0, 0, 0, "lsu_single_drop");

    // Contention: LSU first, IFU blocked, IFU in the IDLE cycle after.
    step(0, 1, 1, B_SINGLE, B_SINGLE, 1, 1, 0, 0, "tie_lsu_addr");
    step(0, 1, 1, B_SINGLE, B_SINGLE, 1, 1, 0, 1, "tie_lsu_data");
    step(0, 0, 1, B_SINGLE, B_SINGLE, 1, 0, 1, 0, "tie_ifu_addr");
    step(0, 0, 1, B_SINGLE, B_SINGLE, 1, 0, 1, 1, "tie_ifu_data");
    step(0, 0, 0, B_SINGLE, B_SINGLE, 1, 0, 0, 0, "tie_idle");

    // IFU INCR4, LSU arrives in beat 2: IFU keeps 5 cycles, then LSU.
    step(0, 0, 1, B_SINGLE, B_INCR4, 1, 0, 1, 0, "i4_addr");
    step(0, 0, 1, B_SINGLE, B_INCR4, 1, 0, 1, 1, "i4_beat1");
    step(0, 1, 1, B_SINGLE, B_INCR4, 1, 0, 1, 1, "i4_beat2");
    step(0, 1, 1, B_SINGLE, B_INCR4, 1, 0, 1, 1, "i4_beat3");
    step(0, 1, 1, B_SINGLE, B_INCR4, 1, 0, 1, 1, "i4_beat4");
    step(0, 1, 0, B_SINGLE, B_SINGLE, 1, 1, 0, 0, "i4_lsu_addr");
    step(0, 0, 0, B_SINGLE, B_SINGLE, 1, 1, 0, 1, "i4_lsu_data_reqdrop");
    step(0, 0, 0, B_SINGLE, B_SINGLE, 1, 0, 0, 0, "i4_idle");

    // LSU address stalled in ADDR; burst sampled at accept (INCR -> 1 beat).
    step(0, 1, 0, B_INCR4, B_SINGLE, 0, 1, 0, 0, "addr_wait_idle");
    step(0, 0, 1, B_INCR4, B_SINGLE, 0, 1, 0, 1, "addr_hold");
    step(0, 0, 1, B_INCR, B_SINGLE, 1, 1, 0, 1, "addr_accept");
    step(0, 0, 1, B_INCR4, B_SINGLE, 1, 1, 0, 1, "addr_single_data");
    step(0, 0, 1, B_SINGLE, B_SINGLE, 1, 0, 1, 0, "addr_ifu_addr");
    step(0, 0, 0, B_SINGLE, B_SINGLE, 1, 0, 1, 1, "addr_ifu_data");
    step(0, 0, 0, B_SINGLE, B_SINGLE, 1, 0, 0, 0, "addr_idle");

    // IFU INCR8 with wait states on beats 3-4: 11 owned cycles.
    step(0, 0, 1, B_SINGLE, B_INCR8, 1, 0, 1, 0, "i8_addr");
    step(0, 0, 1, B_SINGLE, B_INCR8, 1, 0, 1, 1, "i8_beat1");
    step(0, 1, 1, B_SINGLE, B_INCR16, 1, 0, 1, 1, "i8_beat2_burst_change");
    step(0, 1, 1, B_SINGLE, B_INCR16, 0, 0, 1, 1, "i8_beat3_wait");
    step(0, 1, 0, B_SINGLE, B_SINGLE, 0, 0, 1, 1, "i8_beat4_wait");
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, B_SINGLE, B_SINGLE, 1, 0, 1, 1, "i8_tail");
    end
    step(0, 0, 0, B_SINGLE, B_SINGLE, 1, 0, 0, 0, "i8_release");

    // Starvation limit 4: L L L L I L L L L I.
    for (int k = 0; k < 10; k++) begin
      w_ifu = (k == 4) || (k == 9);
      step(0, 1, 1, B_SINGLE, B_SINGLE, 1, !w_ifu, w_ifu, 0, "starve_arb");
      step(0, 1, 1, B_SINGLE, B_SINGLE, 1, !w_ifu, w_ifu, 1, "starve_data");
    end
    step(0, 0, 0, B_SINGLE, B_SINGLE, 1, 0, 0, 0, "starve_idle");

    // Asynchronous reset at beat 7 of an IFU INCR16.
    step(0, 0, 1, B_SINGLE, B_INCR16, 1, 0, 1, 0, "i16_addr");
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 1, B_SINGLE, B_INCR16, 1, 0, 1, 1, "i16_beat");
    end
    @(negedge HCLK);
    #1;
    HRESET = 1'b1;
    #1;
    check("async_reset_outputs", {3'd0, LSUGrant, IFUGrant, LSUDisable, IFUDisable, BusBusy}, 8'd0);
    step(1, 0, 1, B_SINGLE, B_INCR16, 1, 0, 0, 0, "rst_hold");
    step(0, 0, 0, B_SINGLE, B_SINGLE, 1, 0, 0, 0, "post_rst_idle");
    @(negedge HCLK);
    #1;
    check("post_rst_beatcnt", {3'd0, dut.beat_cnt}, 8'd0);
    step(0, 1, 0, B_SINGLE, B_SINGLE, 1, 1, 0, 0, "post_rst_lsu_addr");
    step(0, 0, 0, B_SINGLE, B_SINGLE, 1, 1, 0, 1, "post_rst_lsu_data");
    step(0, 0, 0, B_SINGLE, B_SINGLE, 1, 0, 0, 0, "post_rst_idle2");

    repeat (3) @(posedge HCLK);
    check("scoreboard_drained", 8'(sb_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
